dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder: the memory end of the core's load/store request/response interface.
- Accepts one request at a time over a valid/ready handshake and holds word storage internally.
- Performs RV32 byte/half/word loads with sign or zero extension, and byte-masked stores.
- Returns a response carrying read data and an error flag; sits beside the core in the processor top, in the data-memory position.

Parameters:
- WORD_SIZE, 32, data width in bits; only 32 supported.
- DEPTH, 1024, number of storage words.
- ADDR_WIDTH, 32, byte-address width.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  synchronous reset, active-high.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  responder can accept a request.
- req_we_i  input  1  1 = store, 0 = load.
- req_addr_i  input  ADDR_WIDTH  byte address.
- req_size_i  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned_i  input  1  zero-extend loads (LBU/LHU).
- req_wdata_i  input  WORD_SIZE  store data, right-aligned.
- rsp_valid_o  output  1  response present.
- rsp_ready_i  input  1  core accepts the response.
- rsp_rdata_o  output  WORD_SIZE  extended load data; 0 for stores and errors.
- rsp_err_o  output  1  misaligned, out-of-range or illegal size.

Behaviour:
- Interface decided: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset values: state IDLE, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0. Storage contents are not reset.
- FSM, IDLE: req_ready_o=1. On req_valid_i&&req_ready_o, latch we/addr/size/unsigned/wdata, go to ACCESS.
- FSM, ACCESS: req_ready_o=0. Do a synchronous array read, or the masked write if the request is legal. Compute err. Go to RESP.
- FSM, RESP: rsp_valid_o=1, with rdata and err held stable. On rsp_ready_i, go to IDLE next cycle.
- Latency: handshake in cycle N gives rsp_valid_o high in N+2. If rsp_ready_i is high in N+2, req_ready_o is high in N+3. Minimum spacing between accepted requests is 3 cycles.
- rsp_valid_o, once high, stays high with unchanged data until rsp_ready_i.
- Word index = addr[ADDR_WIDTH-1:2]; byte lane = addr[1:0].
- Error if any of:
  - size=11;
  - size=01 with addr[0]=1;
  - size=10 with addr[1:0]!=0;
  - word index >= DEPTH.
- On error: no array write, rsp_rdata_o=0, rsp_err_o=1.
- Store byte: write lane addr[1:0] with wdata[7:0]; other lanes unchanged.
- Store half: write lanes addr[1]*2 and +1 with wdata[15:0].
- Store word: write all lanes. Store response: rdata=0, err=0.
- Load: extract the selected byte/half/word. Sign-extend from bit 7/15 unless req_unsigned_i; req_unsigned_i is ignored for word.
- A store followed by a load to the same word returns the new data; a store completes in ACCESS, before its response.
- req_* inputs are ignored outside IDLE.
- rst_i in any state forces IDLE with reset values next cycle. rst_i asserted in the ACCESS cycle suppresses the pending write. An outstanding response is discarded.

Decomposition:
- Package dmem_pkg holds:
  - size_e enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILLEGAL);
  - state_e enum (IDLE, ACCESS, RESP);
  - WORD_SIZE and byte-lane constants.
- Sub-module load_align: combinational; takes word, lane, size and unsigned; returns the extended result. Reusable by the core's writeback path.
- The FSM, storage and store masking stay in dmem_responder.

Test Plan:
- Store word 0xDEADBEEF at 0x10, then load word at 0x10 -> rdata=0xDEADBEEF, err=0; rsp_valid_o rises exactly 2 cycles after the request handshake.
- Store byte 0x80 at 0x13 onto 0x11223344, then LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LW 0x10 -> 0x80223344.
- LH 0x12 over word 0x8001_7FFF -> 0xFFFF8001; LHU -> 0x00008001; LH 0x10 -> 0x00007FFF.
- Misaligned requests: SW at 0x21 -> err=1 and the word at 0x20 is unchanged (confirm by LW 0x20). LH at 0x05 -> err=1, rdata=0. size=11 -> err=1.
- Out of range: LW at byte address DEPTH*4 -> err=1, rdata=0.
- Backpressure: hold rsp_ready_i=0 for 5 cycles -> rsp_valid_o and rsp_rdata_o stay stable and req_ready_o=0 throughout; a new req_valid_i is ignored until the response handshake completes.
- Reset: assert rst_i in the ACCESS cycle of SW 0xAAAAAAAA at 0x30 -> next cycle rsp_valid_o=0 and req_ready_o=1; a later LW 0x30 returns the old data.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder and its load aligner.
// Latency: none (declarations only).
// Backpressure: not applicable.
//
// Contents: request size and FSM state enums, word/lane geometry, and helpers
// for access legality and store byte-lane masks.
package dmem_pkg;

  localparam int WORD_SIZE = 32;
  localparam int BYTE_W    = 8;
  localparam int NUM_LANES = WORD_SIZE / BYTE_W;
  localparam int LANE_W    = $clog2(NUM_LANES);

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // True when the size code is illegal or the byte lane is not naturally
  // aligned for that size.
  function automatic logic size_lane_err(input size_e size,
                                         input logic [LANE_W-1:0] lane);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lane[0];
      SZ_WORD: return (lane != '0);
      default: return 1'b1;
    endcase
  endfunction

  // Byte lanes touched by an access of the given size at the given lane.
  function automatic logic [NUM_LANES-1:0] lane_mask(input size_e size,
                                                     input logic [LANE_W-1:0] lane);
    case (size)
      SZ_BYTE: return NUM_LANES'(1) << lane;
      SZ_HALF: return NUM_LANES'(3) << {lane[1], 1'b0};
      SZ_WORD: return '1;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Load aligner: picks the byte/half/word out of a memory word and extends it.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
//
// Ports:
//   word_i     - full storage word
//   lane_i     - byte lane of the access (address bits [1:0])
//   size_i     - 00 byte, 01 half, 10 word, 11 illegal (yields 0)
//   unsigned_i - zero-extend byte/half instead of sign-extend
//   data_o     - right-aligned, extended load result
module load_align
  import dmem_pkg::*;
(
  input  logic [WORD_SIZE-1:0] word_i,
  input  logic [LANE_W-1:0]    lane_i,
  input  logic [1:0]           size_i,
  input  logic                 unsigned_i,
  output logic [WORD_SIZE-1:0] data_o
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = word_i[8*lane_i +: 8];
    // Half accesses are half-aligned, so only lane bit 1 picks the half.
    sel_half = word_i[16*lane_i[1] +: 16];
    data_o   = '0;
    case (size_e'(size_i))
      SZ_BYTE: data_o = unsigned_i ? {{(WORD_SIZE-8){1'b0}}, sel_byte}
                                   : {{(WORD_SIZE-8){sel_byte[7]}}, sel_byte};
      SZ_HALF: data_o = unsigned_i ? {{(WORD_SIZE-16){1'b0}}, sel_half}
                                   : {{(WORD_SIZE-16){sel_half[15]}}, sel_half};
      SZ_WORD: data_o = word_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding RV32 load/store against internal word storage.
// Latency: request handshake in cycle N -> response valid in N+2; next request accepted N+3 at best.
// Backpressure: response held stable until rsp_ready_i; req_ready_o low from ACCESS until response taken.
//
// Ports:
//   clk_i, rst_i                   - clock, synchronous active-high reset
//   req_valid_i / req_ready_o      - request handshake
//   req_we_i, req_addr_i,
//   req_size_i, req_unsigned_i,
//   req_wdata_i                    - request fields, sampled on the handshake
//   rsp_valid_o / rsp_ready_i      - response handshake
//   rsp_rdata_o, rsp_err_o         - extended load data (0 for stores/errors), error flag
module dmem_responder #(
  parameter int WORD_SIZE  = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [WORD_SIZE-1:0]  req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [WORD_SIZE-1:0]  rsp_rdata_o,
  output logic                  rsp_err_o
);

  import dmem_pkg::*;

  localparam int IDX_W  = ADDR_WIDTH - LANE_W;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e state_q, state_d;

  // Latched request
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [WORD_SIZE-1:0]  wdata_q;

  // Response registers
  logic [WORD_SIZE-1:0]  rdata_q;
  logic                  err_q;

  // Storage is deliberately not reset.
  logic [WORD_SIZE-1:0]  mem_q [DEPTH];

  logic                  accept;
  logic [IDX_W-1:0]      widx;
  logic [LANE_W-1:0]     lane;
  logic [MEM_AW-1:0]     mem_addr;
  logic                  err_d;
  logic                  wr_en;
  logic [NUM_LANES-1:0]  wmask;
  logic [WORD_SIZE-1:0]  wdata_rep;
  logic [WORD_SIZE-1:0]  rd_word;
  logic [WORD_SIZE-1:0]  load_data;
  logic [WORD_SIZE-1:0]  rdata_d;

  assign widx     = addr_q[ADDR_WIDTH-1:LANE_W];
  assign lane     = addr_q[LANE_W-1:0];
  assign mem_addr = widx[MEM_AW-1:0];

  always_comb begin
    err_d = size_lane_err(size_e'(size_q), lane) || (widx >= IDX_W'(DEPTH));
    wmask = lane_mask(size_e'(size_q), lane);
    // Replicate store data across the word so every enabled lane sees its byte.
    case (size_e'(size_q))
      SZ_BYTE: wdata_rep = {NUM_LANES{wdata_q[7:0]}};
      SZ_HALF: wdata_rep = {(NUM_LANES/2){wdata_q[15:0]}};
      default: wdata_rep = wdata_q;
    endcase
    // A reset landing in ACCESS must not let the store reach the array.
    wr_en   = (state_q == ACCESS) && we_q && !err_d && !rst_i;
    rd_word = mem_q[mem_addr];
    rdata_d = (we_q || err_d) ? '0 : load_data;
  end

  load_align u_load_align (
    .word_i     (rd_word),
    .lane_i     (lane),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (load_data)
  );

  // FSM next state and handshake outputs
  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    accept      = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          accept  = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we_i;
        addr_q  <= req_addr_i;
        size_q  <= req_size_i;
        uns_q   <= req_unsigned_i;
        wdata_q <= req_wdata_i;
      end
      // Response fields are captured once and then held through RESP.
      if (state_q == ACCESS) begin
        rdata_q <= rdata_d;
        err_q   <= err_d;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < NUM_LANES; b++) begin
        if (wmask[b]) mem_q[mem_addr][b*8 +: 8] <= wdata_rep[b*8 +: 8];
      end
    end
  end

  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed literal transactions plus randomized traffic,
// all responses checked every cycle against a byte-addressed memory model.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int AW    = 32;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  always #5 clk_i = ~clk_i;

  dmem_responder #(.WORD_SIZE(32), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_addr_i     (req_addr_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_wdata_i    (req_wdata_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_err_o      (rsp_err_o)
  );

  int ntot = 0;
  int nbad = 0;
  int cyc  = 0;
  bit mon_en   = 1'b0;
  bit rst_prev = 1'b0;

  logic [31:0] mem_m [DEPTH];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wd;
    int          hs;
    logic [31:0] rd;
    logic        err;
  } ent_t;

  ent_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  // Byte-addressed view of memory: an access touches n consecutive bytes.
  function automatic void model(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                input logic uns, input logic [31:0] wd,
                                output logic [31:0] rd, output logic err);
    int n;
    logic [31:0] ba;
    logic [31:0] val;
    case (size)
      2'd0:    n = 1;
      2'd1:    n = 2;
      2'd2:    n = 4;
      default: n = 0;
    endcase
    rd  = 32'h0;
    err = (n == 0) || ((int'(addr[1:0]) % n) != 0) || ((addr >> 2) >= 32'(DEPTH));
    if (err) return;
    val = 32'h0;
    for (int i = 0; i < n; i++) begin
      ba = addr + 32'(i);
      if (we) mem_m[ba >> 2][8*int'(ba[1:0]) +: 8] = wd[8*i +: 8];
      else    val = val | (32'(mem_m[ba >> 2][8*int'(ba[1:0]) +: 8]) << (8*i));
    end
    if (!we) begin
      if (!uns && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8*n));
      rd = val;
    end
  endfunction

  // Per-cycle monitor and scoreboard.
  ent_t e;
  bit   exp_v;
  always @(negedge clk_i) begin
    if (mon_en) begin
      if (rst_prev) begin
        chk("post_rst_req_ready", req_ready_o, 1);
        chk("post_rst_rsp_valid", rsp_valid_o, 0);
        chk("post_rst_rsp_rdata", rsp_rdata_o, 0);
        chk("post_rst_rsp_err",   rsp_err_o,   0);
      end
      if (q.size() != 0) begin
        e = q[0];
        if (cyc == e.hs + 1 && !rst_i) begin
          model(e.we, e.addr, e.size, e.uns, e.wd, e.rd, e.err);
          q[0] = e;
        end
        exp_v = (cyc >= e.hs + 2);
        chk("mon_busy_req_ready", req_ready_o, 0);
        chk("mon_rsp_valid", rsp_valid_o, exp_v);
        if (exp_v) begin
          chk("mon_rsp_rdata", rsp_rdata_o, e.rd);
          chk("mon_rsp_err",   rsp_err_o,   e.err);
          if (rsp_ready_i) void'(q.pop_front());
        end
      end else if (!rst_prev) begin
        chk("mon_idle_req_ready", req_ready_o, 1);
        chk("mon_idle_rsp_valid", rsp_valid_o, 0);
      end
      if (rst_i) q.delete();
      else if (req_valid_i && req_ready_o) begin
        e.we = req_we_i; e.addr = req_addr_i; e.size = req_size_i; e.uns = req_unsigned_i;
        e.wd = req_wdata_i; e.hs = cyc; e.rd = 32'h0; e.err = 1'b0;
        q.push_back(e);
      end
      rst_prev = rst_i;
    end
    cyc++;
  end

  // One complete transaction; called with inputs free (just after a rising edge).
  task automatic xact(input logic we, input logic [31:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] wd, input int hold, input bit spam,
                      input bit lit, input logic [31:0] erd, input logic eerr);
    int n;
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr;
    req_size_i = size; req_unsigned_i = uns; req_wdata_i = wd;
    n = 0;
    @(negedge clk_i);
    while (!req_ready_o && n < 50) begin n++; @(negedge clk_i); end
    if (!req_ready_o) begin
      chk("req_accept_timeout", 0, 1);
      req_valid_i = 1'b0;
      return;
    end
    @(posedge clk_i); #1;
    if (hold == 0) rsp_ready_i = 1'b1;
    if (spam) begin
      // Garbage request while busy; must be ignored.
      req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = $urandom_range(0, 255);
      req_size_i = 2'd2; req_unsigned_i = 1'b0; req_wdata_i = $urandom;
    end else begin
      req_valid_i = 1'b0;
    end
    n = 0;
    @(negedge clk_i);
    while (!rsp_valid_o && n < 20) begin n++; @(negedge clk_i); end
    chk("rsp_seen", rsp_valid_o, 1);
    if (lit) begin
      chk("lit_latency", n, 1);
      chk("lit_rdata", rsp_rdata_o, erd);
      chk("lit_err",   rsp_err_o,   eerr);
    end
    if (hold > 0) begin
      repeat (hold) @(posedge clk_i);
      #1 rsp_ready_i = 1'b1; req_valid_i = 1'b0;
      @(posedge clk_i);
      #1 rsp_ready_i = 1'b0;
    end else begin
      @(posedge clk_i);
      #1 rsp_ready_i = 1'b0; req_valid_i = 1'b0;
    end
  endtask

  // Store whose ACCESS cycle is hit by reset.
  task automatic reset_during_store(input logic [31:0] addr, input logic [31:0] wd);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = addr;
    req_size_i = 2'd2; req_unsigned_i = 1'b0; req_wdata_i = wd;
    @(negedge clk_i);
    chk("rst_test_accept", req_ready_o, 1);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_test_rsp_valid", rsp_valid_o, 0);
    chk("rst_test_req_ready", req_ready_o, 1);
    @(posedge clk_i); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, ntot=%0d", ntot);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    rst_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0;
    req_size_i = '0; req_unsigned_i = 1'b0; req_wdata_i = '0; rsp_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 mon_en = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Give every word used by random traffic a known value.
    for (int w = 0; w < 64; w++)
      xact(1, 32'(w*4), 2'd2, 0, $urandom, $urandom_range(0, 1), 0, 1, 32'h0, 0);

    xact(1, 32'h10, 2'd2, 0, 32'hDEADBEEF, 0, 0, 1, 32'h0, 0);
    xact(0, 32'h10, 2'd2, 0, 32'h0,        0, 0, 1, 32'hDEADBEEF, 0);

    xact(1, 32'h10, 2'd2, 0, 32'h11223344, 0, 0, 1, 32'h0, 0);
    xact(1, 32'h13, 2'd0, 0, 32'hABCDEF80, 1, 0, 1, 32'h0, 0);
    xact(0, 32'h13, 2'd0, 0, 32'h0,        0, 0, 1, 32'hFFFFFF80, 0);
    xact(0, 32'h13, 2'd0, 1, 32'h0,        0, 0, 1, 32'h00000080, 0);
    xact(0, 32'h10, 2'd2, 0, 32'h0,        0, 0, 1, 32'h80223344, 0);

    xact(1, 32'h10, 2'd2, 0, 32'h80017FFF, 0, 0, 1, 32'h0, 0);
    xact(0, 32'h12, 2'd1, 0, 32'h0,        0, 0, 1, 32'hFFFF8001, 0);
    xact(0, 32'h12, 2'd1, 1, 32'h0,        0, 0, 1, 32'h00008001, 0);
    xact(0, 32'h10, 2'd1, 0, 32'h0,        0, 0, 1, 32'h00007FFF, 0);
    xact(1, 32'h16, 2'd1, 0, 32'h1234BEEF, 0, 0, 1, 32'h0, 0);
    xact(0, 32'h16, 2'd1, 1, 32'h0,        0, 0, 1, 32'h0000BEEF, 0);

    xact(1, 32'h20, 2'd2, 0, 32'h5555AAAA, 0, 0, 1, 32'h0, 0);
    xact(1, 32'h21, 2'd2, 0, 32'hDEADBEEF, 0, 0, 1, 32'h0, 1);
    xact(0, 32'h20, 2'd2, 0, 32'h0,        0, 0, 1, 32'h5555AAAA, 0);
    xact(0, 32'h05, 2'd1, 0, 32'h0,        0, 0, 1, 32'h0, 1);
    xact(0, 32'h10, 2'd3, 0, 32'h0,        0, 0, 1, 32'h0, 1);
    xact(1, 32'h20, 2'd3, 0, 32'hFFFFFFFF, 0, 0, 1, 32'h0, 1);
    xact(0, 32'h20, 2'd2, 0, 32'h0,        0, 0, 1, 32'h5555AAAA, 0);

    xact(0, 32'(DEPTH*4), 2'd2, 0, 32'h0,   0, 0, 1, 32'h0, 1);
    xact(1, 32'(DEPTH*4-4), 2'd2, 0, 32'hCAFEF00D, 0, 0, 1, 32'h0, 0);
    xact(0, 32'(DEPTH*4-4), 2'd2, 0, 32'h0, 0, 0, 1, 32'hCAFEF00D, 0);
    xact(1, 32'(DEPTH*4+3), 2'd0, 0, 32'h11, 0, 0, 1, 32'h0, 1);

    // Backpressure with a stray request held high while busy.
    xact(0, 32'h10, 2'd2, 0, 32'h0, 5, 1, 1, 32'h80017FFF, 0);
    xact(0, 32'h10, 2'd2, 0, 32'h0, 0, 0, 1, 32'h80017FFF, 0);

    xact(1, 32'h30, 2'd2, 0, 32'h12345678, 0, 0, 1, 32'h0, 0);
    reset_during_store(32'h30, 32'hAAAAAAAA);
    xact(0, 32'h30, 2'd2, 0, 32'h0, 0, 0, 1, 32'h12345678, 0);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) a = 32'(DEPTH*4) + 32'($urandom_range(0, 4095));
      else                           a = 32'($urandom_range(0, 255));
      sz = 2'($urandom_range(0, 3));
      xact(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom,
           $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0, 32'h0, 0);
    end

    repeat (3) @(posedge clk_i);
    #1;
    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

endmodule
